// File: rtl/ins_mem_writer_pkg.sv
// Shared definitions for the instruction-memory writer: FSM states and
// memory geometry constants.
package ins_mem_writer_pkg;

    localparam int unsigned MEM_BYTES = 32768;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned MAX_WORDS = MEM_BYTES / 4;
    localparam int unsigned LEN_W     = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ins_mem_writer_word_serializer.sv
// Captures a 32-bit word and emits it as four bytes, most significant first,
// one byte per cycle.
module word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word_in,
    output logic        pending,
    output logic        last_lane,
    output logic [7:0]  byte_out
);

    logic [31:0] word_q;
    logic [1:0]  lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            lane    <= '0;
            pending <= 1'b0;
        end else if (load) begin
            // A reload on the last lane chains words with no gap cycle.
            word_q  <= word_in;
            lane    <= '0;
            pending <= 1'b1;
        end else if (pending) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        byte_out = '0;
        case (lane)
            2'd0:    byte_out = word_q[31:24];
            2'd1:    byte_out = word_q[23:16];
            2'd2:    byte_out = word_q[15:8];
            default: byte_out = word_q[7:0];
        endcase
    end

    assign last_lane = pending && (lane == 2'd3);

endmodule

// File: rtl/ins_mem_writer.sv
// Loads a stream of 32-bit instruction words into byte-wide instruction
// memory, big-endian, and keeps a running checksum of the accepted words.
module ins_mem_writer #(
    parameter int unsigned MEM_BYTES = ins_mem_writer_pkg::MEM_BYTES,
    parameter int unsigned ADDR_W    = ins_mem_writer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [13:0]       len_words,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    import ins_mem_writer_pkg::*;

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MEM_BYTES / 4);

    state_t            state, state_nx;
    logic [LEN_W-1:0]  words_left;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       sum;
    logic              err_q;

    logic              ser_pending;
    logic              ser_last;
    logic [7:0]        ser_byte;

    logic              take_start;
    logic              len_zero;
    logic              len_over;
    logic              accept;
    logic              last_byte;

    word_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .word_in   (word_in),
        .pending   (ser_pending),
        .last_lane (ser_last),
        .byte_out  (ser_byte)
    );

    always_comb begin
        take_start = start && ((state == ST_IDLE) || (state == ST_DONE));
        len_zero   = (len_words == '0);
        len_over   = ({1'b0, len_words} > MAX_LEN);
        // Ready on the final byte lane lets the next word follow back-to-back.
        word_ready = (state == ST_LOAD) && (words_left != '0) && (!ser_pending || ser_last);
        accept     = word_valid && word_ready;
        last_byte  = ser_last && (words_left == '0);

        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = (len_zero || len_over) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_byte) begin
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            words_left <= '0;
            addr       <= '0;
            sum        <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (take_start) begin
                words_left <= len_words;
                addr       <= '0;
                sum        <= '0;
                err_q      <= len_over;
            end
            if (accept) begin
                words_left <= words_left - LEN_W'(1);
                sum        <= sum + word_in;
            end
            if (ser_pending) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign busy      = (state == ST_LOAD);
    assign done      = (state == ST_DONE);
    assign error     = err_q;
    assign checksum  = sum;
    assign mem_we    = ser_pending;
    assign mem_addr  = addr;
    assign mem_wdata = ser_pending ? ser_byte : '0;

endmodule

// File: tb/tb_ins_mem_writer.sv
// Directed bench for ins_mem_writer: a byte-memory model fed by the write
// port, with expected values computed by hand.
module tb_ins_mem_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] len_words;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0] tmem [0:32767];
    int wcnt = 0;
    int exp_addr = 0;
    int contig_err = 0;
    int last_addr = -1;
    int run = 0;
    int maxrun = 0;

    ins_mem_writer #(.MEM_BYTES(32768), .ADDR_W(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len_words  (len_words),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Write-port observer: builds the memory image and tracks address continuity.
    always @(negedge clk) begin
        if (!busy) exp_addr = 0;
        if (mem_we) begin
            tmem[mem_addr] = mem_wdata;
            if (int'(mem_addr) != exp_addr) contig_err++;
            exp_addr  = int'(mem_addr) + 1;
            last_addr = int'(mem_addr);
            wcnt++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [13:0] len);
        start     = 1'b1;
        len_words = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        word_in    = w;
        word_valid = 1'b1;
        while (!word_ready && n < 20) begin
            tick();
            n++;
        end
        if (!word_ready) check("ready_timeout", {31'b0, word_ready}, 32'd1);
        tick();
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        check("done_timeout", {31'b0, done}, 32'd1);
    endtask

    function automatic logic [31:0] rd32(input int a);
        return {tmem[a], tmem[a+1], tmem[a+2], tmem[a+3]};
    endfunction

    initial begin
        int base;
        int cbase;
        rst_n      = 1'b0;
        start      = 1'b0;
        len_words  = '0;
        word_in    = '0;
        word_valid = 1'b0;
        #1;
        check("rst_we",    {31'b0, mem_we},     32'd0);
        check("rst_ready", {31'b0, word_ready}, 32'd0);
        check("rst_busy",  {31'b0, busy},       32'd0);
        check("rst_done",  {31'b0, done},       32'd0);
        check("rst_error", {31'b0, error},      32'd0);
        check("rst_sum",   checksum,            32'd0);
        check("rst_addr",  {17'b0, mem_addr},   32'd0);
        check("rst_wdata", {24'b0, mem_wdata},  32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-length load
        base = wcnt;
        do_start(14'd0);
        check("len0_done",  {31'b0, done},  32'd1);
        check("len0_error", {31'b0, error}, 32'd0);
        check("len0_busy",  {31'b0, busy},  32'd0);
        tick();
        check("len0_writes", wcnt - base, 32'd0);

        // Oversized load
        base = wcnt;
        do_start(14'd9000);
        check("over_done",  {31'b0, done},  32'd1);
        check("over_error", {31'b0, error}, 32'd1);
        tick();
        check("over_writes", wcnt - base, 32'd0);

        // Single word
        base = wcnt;
        do_start(14'd1);
        check("w1_busy",  {31'b0, busy},  32'd1);
        check("w1_error", {31'b0, error}, 32'd0);
        check("w1_done",  {31'b0, done},  32'd0);
        check("w1_ready", {31'b0, word_ready}, 32'd1);
        send_word(32'h8C220004);
        word_valid = 1'b0;
        check("w1_ready_after", {31'b0, word_ready}, 32'd0);
        wait_done(20);
        check("w1_mem",    rd32(0),     32'h8C220004);
        check("w1_b0",     {24'b0, tmem[0]}, 32'h8C);
        check("w1_b3",     {24'b0, tmem[3]}, 32'h04);
        check("w1_writes", wcnt - base, 32'd4);
        check("w1_sum",    checksum,    32'h8C220004);
        check("w1_busy_end", {31'b0, busy}, 32'd0);

        // Three words back-to-back
        base  = wcnt;
        cbase = contig_err;
        do_start(14'd3);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        word_valid = 1'b0;
        wait_done(20);
        check("w3_writes", wcnt - base, 32'd12);
        check("w3_run",    maxrun,      32'd12);
        check("w3_last",   last_addr,   32'd11);
        check("w3_contig", contig_err - cbase, 32'd0);
        check("w3_mem8",   rd32(8),     32'h33333333);
        check("w3_sum",    checksum,    32'h66666666);

        // Full-capacity load
        base  = wcnt;
        cbase = contig_err;
        do_start(14'd8192);
        for (int i = 0; i < 8192; i++) send_word(32'hFFFFFFFF);
        word_valid = 1'b0;
        wait_done(20);
        check("full_writes", wcnt - base, 32'd32768);
        check("full_last",   last_addr,   32'd32767);
        check("full_contig", contig_err - cbase, 32'd0);
        check("full_sum",    checksum,    32'hFFFFE000);
        check("full_error",  {31'b0, error}, 32'd0);

        // Reset in the middle of a word
        base = wcnt;
        do_start(14'd2);
        send_word(32'hA1B2C3D4);
        word_valid = 1'b0;
        tick();
        tick();
        check("mid_we_before", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_we",    {31'b0, mem_we},     32'd0);
        check("mid_busy",  {31'b0, busy},       32'd0);
        check("mid_ready", {31'b0, word_ready}, 32'd0);
        check("mid_sum",   checksum,            32'd0);
        check("mid_writes", wcnt - base, 32'd2);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_idle_done", {31'b0, done}, 32'd0);
        base  = wcnt;
        cbase = contig_err;
        do_start(14'd1);
        send_word(32'h5A3C96E1);
        word_valid = 1'b0;
        wait_done(20);
        check("mid_mem",    rd32(0),     32'h5A3C96E1);
        check("mid_writes2", wcnt - base, 32'd4);
        check("mid_contig", contig_err - cbase, 32'd0);

        // Valid gaps with a stray start during the load
        base  = wcnt;
        cbase = contig_err;
        do_start(14'd3);
        send_word(32'h01234567);
        word_valid = 1'b0;
        tick();
        start     = 1'b1;
        len_words = 14'd1;
        tick();
        start     = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("gap_busy",   {31'b0, busy}, 32'd1);
        check("gap_writes", wcnt - base,   32'd4);
        check("gap_sum1",   checksum,      32'h01234567);
        send_word(32'h89ABCDEF);
        word_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        send_word(32'hDEADBEEF);
        word_valid = 1'b0;
        wait_done(30);
        check("gap_writes_all", wcnt - base, 32'd12);
        check("gap_contig", contig_err - cbase, 32'd0);
        check("gap_last",   last_addr, 32'd11);
        check("gap_mem0",   rd32(0),   32'h01234567);
        check("gap_mem4",   rd32(4),   32'h89ABCDEF);
        check("gap_mem8",   rd32(8),   32'hDEADBEEF);
        check("gap_sum",    checksum,  32'h697CD245);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
